// File: rtl/skew_buf_pkg.sv
// Shared types and helpers for the ping-pong skew buffer.
package skew_buf_pkg;

  typedef enum logic {
    StIdle,
    StDrain
  } state_e;

  typedef logic bank_idx_t;

  // Number of enabled drain steps needed to emit one full skewed tile.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned depth);
    return rows + depth - 1;
  endfunction

endpackage

// File: rtl/skew_bank.sv
// One ROWS x DEPTH tile store: single row-write port, combinational diagonal read.
module skew_bank
  import skew_buf_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RowW       = $clog2(ROWS),
  parameter int unsigned StepW      = $clog2(drain_len(ROWS, DEPTH))
) (
  input  logic                         clk_i,
  input  logic                         wr_en_i,
  input  logic [RowW-1:0]              wr_row_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i [DEPTH],
  input  logic [StepW-1:0]             rd_step_i,
  output logic signed [DATA_WIDTH-1:0] rd_data_o [ROWS],
  output logic [ROWS-1:0]              rd_win_o
);

  localparam int unsigned ColW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [DATA_WIDTH-1:0] mem_q [ROWS][DEPTH];

  // Storage is deliberately left unreset; the full flags gate its use.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        mem_q[wr_row_i][j] <= wr_data_i[j];
      end
    end
  end

  // Lane i reads element (t - i) while that index falls inside the lane.
  always_comb begin
    for (int i = 0; i < int'(ROWS); i++) begin
      int diff;
      diff         = int'(rd_step_i) - i;
      rd_data_o[i] = '0;
      rd_win_o[i]  = 1'b0;
      if (diff >= 0 && diff < int'(DEPTH)) begin
        rd_win_o[i]  = 1'b1;
        rd_data_o[i] = mem_q[i][ColW'(diff)];
      end
    end
  end

endmodule

// File: rtl/pingpong_skew_buffer.sv
// Double-buffered diagonal skew feeder for systolic array edge lanes.
// Optional SKEW_BUF_STATS_EN adds stall_cycles / tiles_done counters.
module pingpong_skew_buffer
  import skew_buf_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic signed [DATA_WIDTH-1:0] wr_data [DEPTH],
  input  logic                         rd_enable,
  output logic signed [DATA_WIDTH-1:0] data_out [ROWS],
  output logic [ROWS-1:0]              lane_valid,
  output logic                         tile_done,
  output logic                         busy
`ifdef SKEW_BUF_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [15:0]                  tiles_done
`endif
);

  localparam int unsigned DrainLen = drain_len(ROWS, DEPTH);
  localparam int unsigned StepW    = $clog2(DrainLen);
  localparam int unsigned RowW     = $clog2(ROWS);
  localparam logic [StepW-1:0] LastStep = StepW'(DrainLen - 1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(ROWS - 1);

  state_e           state_q, state_d;
  logic [StepW-1:0] t_q, t_d;
  bank_idx_t        wb_q, wb_d, rb_q, rb_d;
  logic [1:0]       full_q, full_d;
  logic [RowW-1:0]  wr_row_q, wr_row_d;

  logic wr_fire, draining, last_step;

  logic signed [DATA_WIDTH-1:0] rd_data0 [ROWS];
  logic signed [DATA_WIDTH-1:0] rd_data1 [ROWS];
  logic [ROWS-1:0]              rd_win0, rd_win1;

  assign wr_ready  = !full_q[wb_q];
  assign wr_fire   = wr_valid && wr_ready;
  assign draining  = (state_q == StDrain);
  assign last_step = draining && rd_enable && (t_q == LastStep);
  assign tile_done = last_step;
  assign busy      = draining || full_q[0] || full_q[1];

  skew_bank #(
    .ROWS       (ROWS),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RowW       (RowW),
    .StepW      (StepW)
  ) u_bank0 (
    .clk_i     (clk),
    .wr_en_i   (wr_fire && (wb_q == 1'b0)),
    .wr_row_i  (wr_row_q),
    .wr_data_i (wr_data),
    .rd_step_i (t_q),
    .rd_data_o (rd_data0),
    .rd_win_o  (rd_win0)
  );

  skew_bank #(
    .ROWS       (ROWS),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RowW       (RowW),
    .StepW      (StepW)
  ) u_bank1 (
    .clk_i     (clk),
    .wr_en_i   (wr_fire && (wb_q == 1'b1)),
    .wr_row_i  (wr_row_q),
    .wr_data_i (wr_data),
    .rd_step_i (t_q),
    .rd_data_o (rd_data1),
    .rd_win_o  (rd_win1)
  );

  always_comb begin
    for (int i = 0; i < int'(ROWS); i++) begin
      data_out[i] = '0;
      if (draining) begin
        data_out[i] = rb_q ? rd_data1[i] : rd_data0[i];
      end
    end
    lane_valid = (draining && rd_enable) ? (rb_q ? rd_win1 : rd_win0) : '0;
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    full_d   = full_q;
    wr_row_d = wr_row_q;

    if (wr_fire) begin
      if (wr_row_q == LastRow) begin
        wr_row_d     = '0;
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rb_q]) begin
          state_d = StDrain;
          t_d     = '0;
        end
      end
      StDrain: begin
        if (rd_enable) begin
          if (t_q == LastStep) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            t_d          = '0;
            // Registered flag: a tile completing on this same edge waits one bubble.
            if (!full_q[~rb_q]) begin
              state_d = StIdle;
            end
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      t_q      <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      full_q   <= '0;
      wr_row_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      full_q   <= full_d;
      wr_row_q <= wr_row_d;
    end
  end

`ifdef SKEW_BUF_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] tiles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      tiles_q <= '0;
    end else begin
      if (draining && !rd_enable && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (tile_done) begin
        tiles_q <= tiles_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign tiles_done   = tiles_q;
`endif

endmodule

// File: tb/tb_pingpong_skew_buffer.sv
// Directed bench for pingpong_skew_buffer with ROWS=4, DEPTH=3.
module tb_pingpong_skew_buffer;

  localparam int R = 4;
  localparam int D = 3;
  localparam int W = 8;
  localparam int LastT = R + D - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic rd_enable = 1'b0;
  logic signed [W-1:0] wr_data [D];
  logic wr_ready, tile_done, busy;
  logic signed [W-1:0] data_out [R];
  logic [R-1:0] lane_valid;
`ifdef SKEW_BUF_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] tiles_done;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pingpong_skew_buffer #(
    .ROWS       (R),
    .DEPTH      (D),
    .DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_enable  (rd_enable),
    .data_out   (data_out),
    .lane_valid (lane_valid),
    .tile_done  (tile_done),
    .busy       (busy)
`ifdef SKEW_BUF_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .tiles_done   (tiles_done)
`endif
  );

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input int i, input int t);
    return (t >= i) && (t - i < D);
  endfunction

  function automatic int exp_lane(input int base, input int i, input int t);
    if (in_win(i, t)) return base + 10 * i + (t - i);
    return 0;
  endfunction

  task automatic write_beat(input int base, input int r);
    wr_valid = 1'b1;
    for (int j = 0; j < D; j++) wr_data[j] = W'(base + 10 * r + j);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_tile(input int base);
    for (int r = 0; r < R; r++) write_beat(base, r);
  endtask

  task automatic check_step(input string tag, input int base, input int t, input bit en);
    logic [R-1:0] ev;
    ev = '0;
    #1;
    for (int i = 0; i < R; i++) begin
      chk($sformatf("%s_t%0d_lane%0d", tag, t, i), data_out[i], exp_lane(base, i, t));
      ev[i] = en && in_win(i, t);
    end
    chk($sformatf("%s_t%0d_lane_valid", tag, t), lane_valid, ev);
    chk($sformatf("%s_t%0d_tile_done", tag, t), tile_done, (en && t == LastT) ? 1 : 0);
  endtask

  task automatic check_reset(input string tag);
    #1;
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tile_done"}, tile_done, 0);
    chk({tag, "_lane_valid"}, lane_valid, 0);
    for (int i = 0; i < R; i++) chk($sformatf("%s_data%0d", tag, i), data_out[i], 0);
  endtask

  initial begin
    int ones;
    for (int j = 0; j < D; j++) wr_data[j] = '0;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");
`ifdef SKEW_BUF_STATS_EN
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_tiles_done", tiles_done, 0);
`endif

    // Single tile, continuous drain
    write_tile(0);
    chk("t1_busy_after_write", busy, 1);
    chk("t1_idle_no_valid", lane_valid, 0);
    rd_enable = 1'b1;
    tick();
    ones = 0;
    for (int t = 0; t <= LastT; t++) begin
      check_step("t1", 0, t, 1'b1);
      ones += $countones(lane_valid);
      tick();
    end
    chk("t1_valid_ones", ones, 12);
    chk("t1_busy_done", busy, 0);

    // Back-to-back tiles: second completes before first's last step
    write_tile(0);
    write_tile(50);
    chk("t2_wr_ready_both_full", wr_ready, 0);
    for (int k = 0; k < 9; k++) begin
      if (k < 3) check_step("t2a", 0, k + 3, 1'b1);
      else check_step("t2b", 50, k - 3, 1'b1);
      tick();
    end
    chk("t2_busy_done", busy, 0);
    chk("t2_lane_valid_done", lane_valid, 0);

    // Both banks filled with no drain; a 9th offer must be ignored
    rd_enable = 1'b0;
    write_tile(40);
    write_tile(60);
    chk("t3_wr_ready_low", wr_ready, 0);
    chk("t3_busy", busy, 1);
    wr_valid = 1'b1;
    for (int j = 0; j < D; j++) wr_data[j] = W'(99);
    tick();
    wr_valid = 1'b0;
    chk("t3_wr_ready_still_low", wr_ready, 0);
    check_step("t3_stall", 40, 0, 1'b0);
    rd_enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 6) check_step("t3c", 40, k, 1'b1);
      else check_step("t3d", 60, k - 6, 1'b1);
      tick();
    end
    chk("t3_busy_done", busy, 0);

    // Three-cycle stall at t=3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t4_rst");
    write_tile(20);
    tick();
    for (int t = 0; t < 3; t++) begin
      check_step("t4", 20, t, 1'b1);
      tick();
    end
    rd_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_step("t4_stall", 20, 3, 1'b0);
      tick();
    end
    rd_enable = 1'b1;
    for (int t = 3; t <= LastT; t++) begin
      check_step("t4_resume", 20, t, 1'b1);
      tick();
    end
    chk("t4_busy_done", busy, 0);
`ifdef SKEW_BUF_STATS_EN
    chk("t4_stall_cycles", stall_cycles, 3);
    chk("t4_tiles_done", tiles_done, 1);
`endif

    // Reset mid-drain with a partial tile pending in the other bank
    rd_enable = 1'b0;
    write_tile(70);
    write_beat(90, 0);
    write_beat(90, 1);
    rd_enable = 1'b1;
    for (int t = 0; t < 3; t++) begin
      check_step("t5", 70, t, 1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_enable = 1'b0;
    check_reset("t5_rst");
`ifdef SKEW_BUF_STATS_EN
    chk("t5_rst_stall_cycles", stall_cycles, 0);
    chk("t5_rst_tiles_done", tiles_done, 0);
`endif
    rd_enable = 1'b1;
    write_tile(5);
    tick();
    for (int t = 0; t <= LastT; t++) begin
      check_step("t5_new", 5, t, 1'b1);
      tick();
    end
    chk("t5_busy_done", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
